// File: rtl/fht_adc_loader_if.sv
// ADC-to-FHT loader bus: sample stream, FHT handshake and banked RAM write port.
// Macro FHT_LOADER_BIAS_EN adds the iBIAS input.
interface fht_adc_loader_if #(
  parameter int unsigned D_BIT = 16,
  parameter int unsigned A_BIT = 8,
  parameter int unsigned B_BIT = 2
);
  logic                      iARM;
  logic                      iVALID;
  logic [D_BIT-2:0]          iSAMPLE;
  logic                      iFHT_RDY;
`ifdef FHT_LOADER_BIAS_EN
  logic [D_BIT-2:0]          iBIAS;
`endif
  logic [A_BIT-1:0]          oADDR_WR;
  logic [D_BIT-1:0]          oDATA;
  logic [(1 << B_BIT)-1:0]   oWE;
  logic                      oFHT_START;
  logic                      oBUSY;
  logic                      oFRAME_DONE;
  logic                      oOVERRUN;

  modport slave (
    input  iARM, iVALID, iSAMPLE, iFHT_RDY,
`ifdef FHT_LOADER_BIAS_EN
    input  iBIAS,
`endif
    output oADDR_WR, oDATA, oWE, oFHT_START, oBUSY, oFRAME_DONE, oOVERRUN
  );

  modport master (
    output iARM, iVALID, iSAMPLE, iFHT_RDY,
`ifdef FHT_LOADER_BIAS_EN
    output iBIAS,
`endif
    input  oADDR_WR, oDATA, oWE, oFHT_START, oBUSY, oFRAME_DONE, oOVERRUN
  );
endinterface

// File: rtl/fht_adc_loader.sv
// Captures one frame of ADC samples into bit-reversed RAM banks, kicks the FHT and waits for it.
// Optional macro FHT_LOADER_BIAS_EN: subtract iBIAS from each sample before the write.
module fht_adc_loader #(
  parameter int unsigned D_BIT = 16,
  parameter int unsigned A_BIT = 8,
  parameter int unsigned B_BIT = 2
) (
  input logic             iCLK,
  input logic             iRESET,
  fht_adc_loader_if.slave bus
);
  localparam int unsigned N_BANK = 1 << B_BIT;
  localparam int unsigned CNT_W  = A_BIT + B_BIT;
  localparam int unsigned S_BIT  = D_BIT - 1;

  typedef enum logic [1:0] {IDLE, FILL, KICK, WAIT_FHT} state_t;

  state_t              state;
  logic [CNT_W-1:0]    k;
  logic                rdy_low_seen;
  logic [A_BIT-1:0]    addr_q;
  logic [D_BIT-1:0]    data_q;
  logic [N_BANK-1:0]   we_q;
  logic                start_q;
  logic                busy_q;
  logic                done_q;
  logic                overrun_q;

  logic [B_BIT-1:0]    bank_rev_c;
  logic [N_BANK-1:0]   we_onehot_c;
  logic [D_BIT-1:0]    sample_ext_c;
  logic [D_BIT-1:0]    word_c;
  logic                k_last_c;

  // Bank select is the bit-reversed upper counter field; sample is sign-extended (minus bias).
  always_comb begin
    bank_rev_c = '0;
    for (int unsigned i = 0; i < B_BIT; i++) begin
      bank_rev_c[i] = k[CNT_W-1-i];
    end
    we_onehot_c  = N_BANK'(1) << bank_rev_c;
    sample_ext_c = {bus.iSAMPLE[S_BIT-1], bus.iSAMPLE};
`ifdef FHT_LOADER_BIAS_EN
    word_c = sample_ext_c - {bus.iBIAS[S_BIT-1], bus.iBIAS};
`else
    word_c = sample_ext_c;
`endif
    k_last_c = (k == {CNT_W{1'b1}});
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state        <= IDLE;
      k            <= '0;
      rdy_low_seen <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      we_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iARM) begin
            state     <= FILL;
            k         <= '0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        FILL: begin
          if (bus.iVALID) begin
            addr_q <= k[A_BIT-1:0];
            data_q <= word_c;
            we_q   <= we_onehot_c;
            k      <= k + CNT_W'(1);
            if (k_last_c) begin
              state <= KICK;
            end
          end
        end
        KICK: begin
          start_q      <= 1'b1;
          rdy_low_seen <= 1'b0;
          state        <= WAIT_FHT;
          if (bus.iVALID) begin
            overrun_q <= 1'b1;
          end
        end
        WAIT_FHT: begin
          if (bus.iVALID) begin
            overrun_q <= 1'b1;
          end
          // Only a low-to-high transition seen after the kick counts as completion.
          if (!bus.iFHT_RDY) begin
            rdy_low_seen <= 1'b1;
          end else if (rdy_low_seen) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oADDR_WR    = addr_q;
  assign bus.oDATA       = data_q;
  assign bus.oWE         = we_q;
  assign bus.oFHT_START  = start_q;
  assign bus.oBUSY       = busy_q;
  assign bus.oFRAME_DONE = done_q;
  assign bus.oOVERRUN    = overrun_q;
endmodule

// File: tb/tb_fht_adc_loader.sv
// Scoreboard bench for fht_adc_loader: driver queues expected writes/pulses, negedge monitor checks them.
module tb_fht_adc_loader;
  localparam int unsigned D_BIT = 16;
  localparam int unsigned A_BIT = 8;
  localparam int unsigned B_BIT = 2;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [3:0]  we;
    logic [15:0] data;
  } wr_t;

  logic iCLK = 1'b0;
  logic iRESET = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  wr_t  wq[$];
  int   start_q[$];
  int   done_q[$];
  int   bank_map[4] = '{0, 2, 1, 3};

  fht_adc_loader_if #(.D_BIT(D_BIT), .A_BIT(A_BIT), .B_BIT(B_BIT)) bus ();

  fht_adc_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .B_BIT(B_BIT)) u_dut (
    .iCLK  (iCLK),
    .iRESET(iRESET),
    .bus   (bus)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Hand-computed stimulus and expected RAM word per sample index.
  task automatic stim(input int k, output logic [14:0] s, output logic [14:0] b,
                      output logic [15:0] d);
    s = 15'(k);
    b = '0;
    d = 16'(k);
    if (k == 5) begin s = 15'h7FFF; d = 16'hFFFF; end
    if (k == 6) begin s = 15'h4000; d = 16'hC000; end
`ifdef FHT_LOADER_BIAS_EN
    if (k == 7) begin s = 15'd100; b = 15'h4000; d = 16'd16484; end
    if (k == 8) begin s = 15'd0;   b = 15'h3FFF; d = 16'hC001; end
`endif
  endtask

  task automatic run_fill(input int gap, input int n);
    logic [14:0] s;
    logic [14:0] b;
    logic [15:0] d;
    wr_t e;
    for (int k = 0; k < n; k++) begin
      tick();
      stim(k, s, b, d);
      bus.iVALID  = 1'b1;
      bus.iSAMPLE = s;
`ifdef FHT_LOADER_BIAS_EN
      bus.iBIAS   = b;
`endif
      bus.iARM    = (k == 100);
      e.cyc  = cyc + 1;
      e.addr = 8'(k % 256);
      e.we   = 4'(1 << bank_map[k / 256]);
      e.data = d;
      wq.push_back(e);
      if (k == 1023) start_q.push_back(cyc + 2);
      if (k == 10) check("busy_in_fill", 32'(bus.oBUSY), 32'd1);
      for (int g = 1; g < gap; g++) begin
        tick();
        bus.iVALID = 1'b0;
        bus.iARM   = 1'b0;
      end
    end
    tick();
    bus.iVALID = 1'b0;
    bus.iARM   = 1'b0;
  endtask

  task automatic raise_rdy();
    bus.iFHT_RDY = 1'b1;
    done_q.push_back(cyc + 1);
    tick();
    check("busy_after_done", 32'(bus.oBUSY), 32'd0);
  endtask

  // Monitor: every write / pulse must match the head of its expectation queue.
  always @(negedge iCLK) begin
    if (iRESET) begin
      if (bus.oWE != 4'd0) begin
        n_tests++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: we=%0h addr=%0h data=%0h at cycle %0d",
                   bus.oWE, bus.oADDR_WR, bus.oDATA, cyc);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (e.cyc != cyc || e.addr !== bus.oADDR_WR || e.we !== bus.oWE ||
              e.data !== bus.oDATA) begin
            n_fail++;
            $display("FAIL write: got cyc=%0d we=%0h addr=%0h data=%0h expected cyc=%0d we=%0h addr=%0h data=%0h",
                     cyc, bus.oWE, bus.oADDR_WR, bus.oDATA, e.cyc, e.we, e.addr, e.data);
          end
        end
      end
      if (bus.oFHT_START) begin
        n_tests++;
        if (start_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_start: got pulse at cycle %0d expected none", cyc);
        end else begin
          int c;
          c = start_q.pop_front();
          if (c != cyc) begin
            n_fail++;
            $display("FAIL start_cycle: got %0d expected %0d", cyc, c);
          end
        end
      end
      if (bus.oFRAME_DONE) begin
        n_tests++;
        if (done_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
        end else begin
          int c;
          c = done_q.pop_front();
          if (c != cyc) begin
            n_fail++;
            $display("FAIL done_cycle: got %0d expected %0d", cyc, c);
          end
        end
      end
    end
  end

  initial begin
    bus.iARM     = 1'b0;
    bus.iVALID   = 1'b0;
    bus.iSAMPLE  = '0;
    bus.iFHT_RDY = 1'b1;
`ifdef FHT_LOADER_BIAS_EN
    bus.iBIAS    = '0;
`endif
    repeat (3) tick();
    check("rst_we", 32'(bus.oWE), 32'd0);
    check("rst_busy", 32'(bus.oBUSY), 32'd0);
    check("rst_start", 32'(bus.oFHT_START), 32'd0);
    check("rst_overrun", 32'(bus.oOVERRUN), 32'd0);
    iRESET = 1'b1;
    tick();

    // Frame A: contiguous ramp, arm during fill, overrun and arm during FHT wait.
    bus.iARM = 1'b1;
    bus.iVALID = 1'b1;
    tick();
    bus.iARM = 1'b0;
    bus.iVALID = 1'b0;
    check("arm_busy", 32'(bus.oBUSY), 32'd1);
    run_fill(1, 1024);
    tick();
    tick();
    bus.iFHT_RDY = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      bus.iVALID = (i == 100);
      bus.iARM   = (i == 200);
      if (i == 102) check("overrun_set", 32'(bus.oOVERRUN), 32'd1);
      if (i == 202) check("busy_wait_after_arm", 32'(bus.oBUSY), 32'd1);
    end
    tick();
    bus.iVALID = 1'b0;
    bus.iARM   = 1'b0;
    raise_rdy();
    check("overrun_held", 32'(bus.oOVERRUN), 32'd1);
    tick();
    check("idle_busy", 32'(bus.oBUSY), 32'd0);

    // Frame B: arm+valid together (sample dropped), then gapped valids.
    bus.iARM = 1'b1;
    bus.iVALID = 1'b1;
    bus.iSAMPLE = 15'h0ABC;
    tick();
    bus.iARM = 1'b0;
    bus.iVALID = 1'b0;
    check("overrun_cleared", 32'(bus.oOVERRUN), 32'd0);
    run_fill(3, 1024);
    repeat (3) tick();
    bus.iFHT_RDY = 1'b0;
    repeat (10) tick();
    raise_rdy();
    check("overrun_clean_frame", 32'(bus.oOVERRUN), 32'd0);

    // Frame C: reset at sample 300, then restart from bank0 addr0.
    tick();
    bus.iARM = 1'b1;
    tick();
    bus.iARM = 1'b0;
    run_fill(1, 300);
    tick();
    bus.iVALID = 1'b1;
    bus.iSAMPLE = 15'd300;
    iRESET = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.oWE), 32'd0);
    check("mid_rst_addr", 32'(bus.oADDR_WR), 32'd0);
    check("mid_rst_data", 32'(bus.oDATA), 32'd0);
    check("mid_rst_busy", 32'(bus.oBUSY), 32'd0);
    tick();
    bus.iVALID = 1'b0;
    tick();
    iRESET = 1'b1;
    bus.iARM = 1'b1;
    tick();
    bus.iARM = 1'b0;
    check("first_arm_after_rst", 32'(bus.oBUSY), 32'd1);
    run_fill(1, 1024);
    repeat (2) tick();
    bus.iFHT_RDY = 1'b0;
    repeat (5) tick();
    raise_rdy();

    repeat (5) tick();
    check("writes_pending", 32'(wq.size()), 32'd0);
    check("starts_pending", 32'(start_q.size()), 32'd0);
    check("dones_pending", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fht_adc_loader.md
FHT_ADC_LOADER -- requirements
Module: fht_adc_loader

Interface
REQ-001 Parameter D_BIT, default 16: RAM word width; ADC sample is D_BIT-1 bits signed.
REQ-002 Parameter A_BIT, default 8: bank address width; bank size BANK_SIZE = 2^A_BIT.
REQ-003 Parameter B_BIT, default 2: bank-index width; bank count N_BANK = 2^B_BIT; B_BIT >= 1.
REQ-004 iCLK  in  1  single clock; all logic rising-edge.
REQ-005 iRESET  in  1  asynchronous, active-low reset.
REQ-006 iARM  in  1  one-cycle request to capture a new frame.
REQ-007 iVALID  in  1  ADC sample strobe.
REQ-008 iSAMPLE  in  D_BIT-1  signed ADC sample, no bit expansion.
REQ-009 iFHT_RDY  in  1  FHT core ready/finished flag.
REQ-010 oADDR_WR  out  A_BIT  RAM write address.
REQ-011 oDATA  out  D_BIT  RAM write data, signed.
REQ-012 oWE  out  N_BANK  one-hot per-bank write enable.
REQ-013 oFHT_START  out  1  one-cycle FHT start pulse.
REQ-014 oBUSY  out  1  high in every state except IDLE.
REQ-015 oFRAME_DONE  out  1  one-cycle pulse at end of transform.
REQ-016 oOVERRUN  out  1  sticky lost-sample flag.

Function
REQ-017 FSM states SHALL be IDLE, FILL, KICK, WAIT_FHT.
REQ-018 IDLE: iARM=1 -> FILL, clear sample counter and oOVERRUN; iVALID in IDLE ignored, no flag.
REQ-019 FILL: each iVALID=1 cycle SHALL write one sample; idle cycles hold counters.
REQ-020 Sample counter k spans A_BIT+B_BIT bits; addr = k[A_BIT-1:0], bank counter = k[A_BIT+B_BIT-1:A_BIT] (address inner, bank outer).
REQ-021 Written bank SHALL be the bit-reverse of the bank counter (B_BIT bits); oWE one-hot on that bank.
REQ-022 Write latency: oWE/oADDR_WR/oDATA registered, asserted exactly one cycle after iVALID, high for one cycle.
REQ-023 oDATA SHALL be iSAMPLE sign-extended to D_BIT (subject to REQ-032).
REQ-024 Sample k = N_BANK*BANK_SIZE-1 accepted -> KICK next cycle; counter wraps to 0.
REQ-025 KICK: oFHT_START=1 for exactly one cycle, then WAIT_FHT.
REQ-026 WAIT_FHT: on first cycle with iFHT_RDY=1 after a cycle with iFHT_RDY=0 (rising edge, sampled after KICK) -> oFRAME_DONE pulse one cycle, -> IDLE.
REQ-027 iVALID=1 in KICK or WAIT_FHT SHALL set oOVERRUN (held until next accepted iARM); no write.
REQ-028 iARM outside IDLE ignored; iARM and iVALID same cycle in IDLE: sample not written, first write is next valid.

Reset
REQ-029 iRESET=0 SHALL asynchronously force IDLE, counters 0, all outputs 0, regardless of state (mid-FILL aborts the frame, partial RAM content undefined).
REQ-030 First iARM accepted on the first rising edge after iRESET deasserts.

Configuration
REQ-031 Macro FHT_LOADER_BIAS_EN; absent: no bias port, REQ-023 applies.
REQ-032 Defined: adds input port iBIAS (D_BIT-1, signed), sampled each write; oDATA = sext(iSAMPLE) - sext(iBIAS) in D_BIT bits, never overflows; latency unchanged.

Verification (defaults D_BIT=16, A_BIT=8, B_BIT=2)
REQ-033 Ramp: iARM, then 1024 contiguous valids carrying k=0..1023 -> sample 0 to bank0 addr0, 256 to bank2 addr0, 512 to bank1 addr0, 1023 to bank3 addr255; oFHT_START one cycle after last write cycle.
REQ-034 Gapped valids (every 3rd cycle) -> identical RAM content to REQ-033; writes one cycle after each valid.
REQ-035 Sample -1 (0x7FFF in 15 bits) -> oDATA=0xFFFF; with FHT_LOADER_BIAS_EN, iSAMPLE=100, iBIAS=-16384 -> oDATA=16484.
REQ-036 After KICK, hold iFHT_RDY=1 two cycles, drop 500 cycles, raise -> oFRAME_DONE exactly one cycle after rise, oBUSY low next cycle; iVALID during wait -> oOVERRUN=1, cleared by next iARM.
REQ-037 iRESET=0 at sample 300 mid-FILL -> all outputs 0 immediately; new iARM restarts at bank0 addr0.
REQ-038 iARM during FILL and WAIT_FHT -> no effect on counters or state.
